// File: rtl/pwl_sincos_pipe.sv
// rtl/pwl_sincos_pipe.sv - piecewise-linear sin/cos generator, 3-stage valid/ready pipeline
module pwl_sincos_pipe #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int SEG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    phase,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    y,
  input  logic                cfg_we,
  input  logic [SEG_BITS-1:0] cfg_addr,
  input  logic [WIDTH-1:0]    cfg_slope,
  input  logic [WIDTH-1:0]    cfg_icpt
);

  localparam int SEGS = 1 << SEG_BITS;
  localparam int T    = WIDTH - 2 - SEG_BITS;
  localparam logic [WIDTH-1:0]  QTR     = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic signed [WIDTH:0] POS_LIM = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] NEG_LIM = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

  if (WIDTH < SEG_BITS + 4 || FRAC >= WIDTH) begin : g_bad_params
    $error("pwl_sincos_pipe: WIDTH must be >= SEG_BITS+4 and > FRAC");
  end

  logic [WIDTH-1:0] slope_tab [SEGS];
  logic [WIDTH-1:0] icpt_tab  [SEGS];

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 fold: cos is sin shifted by a quarter turn, odd quadrants mirror the offset
  logic [WIDTH-1:0]    p;
  logic [1:0]          q;
  logic [WIDTH-3:0]    r, rm;
  logic [SEG_BITS-1:0] seg;
  assign p   = phase + (mode ? QTR : '0);
  assign q   = p[WIDTH-1:WIDTH-2];
  assign r   = p[WIDTH-3:0];
  assign rm  = q[0] ? ~r : r;
  assign seg = rm[WIDTH-3 -: SEG_BITS];

  logic                v1, v2;
  logic [WIDTH-1:0]    s1_slope, s1_icpt, s2_icpt;
  logic [T-1:0]        s1_t;
  logic                s1_neg, s2_neg;
  logic [2*WIDTH-1:0]  prod;

  logic signed [2*WIDTH-1:0] mul_a, mul_b;
  assign mul_a = {{WIDTH{s1_slope[WIDTH-1]}}, s1_slope};
  assign mul_b = {{(2*WIDTH-T){1'b0}}, s1_t};

  // The product never exceeds WIDTH+T+1 significant bits, so the slice is the exact shifted value
  logic signed [WIDTH:0] prod_sh, ssum;
  logic [WIDTH-1:0]      s_sat, y_next;
  logic                  prod_unused;
  assign prod_sh     = prod[T+WIDTH:T];
  assign prod_unused = ^{prod[2*WIDTH-1:T+WIDTH+1], prod[T-1:0]};
  assign ssum        = $signed({s2_icpt[WIDTH-1], s2_icpt}) + prod_sh;

  always_comb begin
    s_sat = ssum[WIDTH-1:0];
    if (ssum > POS_LIM)
      s_sat = POS_LIM[WIDTH-1:0];
    else if (ssum < NEG_LIM)
      s_sat = NEG_LIM[WIDTH-1:0];
    y_next = s2_neg ? -s_sat : s_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEGS; i++) begin
        slope_tab[i] <= '0;
        icpt_tab[i]  <= '0;
      end
    end else if (cfg_we) begin
      slope_tab[cfg_addr] <= cfg_slope;
      icpt_tab[cfg_addr]  <= cfg_icpt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_slope  <= '0;
      s1_icpt   <= '0;
      s1_t      <= '0;
      s1_neg    <= 1'b0;
      prod      <= '0;
      s2_icpt   <= '0;
      s2_neg    <= 1'b0;
      y         <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1_slope  <= slope_tab[seg];
      s1_icpt   <= icpt_tab[seg];
      s1_t      <= rm[T-1:0];
      s1_neg    <= q[1];
      v2        <= v1;
      prod      <= mul_a * mul_b;
      s2_icpt   <= s1_icpt;
      s2_neg    <= s1_neg;
      out_valid <= v2;
      if (v2)
        y <= y_next;
    end
  end

endmodule
